// File: rtl/pipe_regfile_pkg.sv
// Shared definitions for the pipelined register file: FSM encoding and default sizing.
package pipe_regfile_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} rf_state_e;
endpackage

// File: rtl/pipe_regfile_if.sv
// Register-file bus: read ports, two writeback ports, issue marking and debug read.
interface pipe_regfile_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
);
  logic [AW-1:0]   rs1, rs2;
  logic [XLEN-1:0] rv1, rv2;
  logic            busy1, busy2;
  logic            wea, web;
  logic [AW-1:0]   rda, rdb;
  logic [XLEN-1:0] wda, wdb;
  logic            issue_valid;
  logic [AW-1:0]   issue_rd;
  logic [AW-1:0]   dbg_addr;
  logic [XLEN-1:0] dbg_rdata;
  logic            ready;

  modport master (
    output rs1, rs2, wea, rda, wda, web, rdb, wdb, issue_valid, issue_rd, dbg_addr,
    input  rv1, rv2, busy1, busy2, dbg_rdata, ready
  );
  modport slave (
    input  rs1, rs2, wea, rda, wda, web, rdb, wdb, issue_valid, issue_rd, dbg_addr,
    output rv1, rv2, busy1, busy2, dbg_rdata, ready
  );
endinterface

// File: rtl/pipe_regfile_scoreboard.sv
// Pending-write scoreboard: issue sets, writeback clears, set beats clear in the same cycle.
module regfile_scoreboard
  import pipe_regfile_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          set_en,
  input  logic [AW-1:0] set_addr,
  input  logic          clr_a_en,
  input  logic [AW-1:0] clr_a,
  input  logic          clr_b_en,
  input  logic [AW-1:0] clr_b,
  input  logic [AW-1:0] rs1,
  input  logic [AW-1:0] rs2,
  output logic          busy1,
  output logic          busy2
);
  logic [NREG-1:0] busy, set_vec, clr_vec;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (set_en)   set_vec[set_addr] = 1'b1;
    if (clr_a_en) clr_vec[clr_a]    = 1'b1;
    if (clr_b_en) clr_vec[clr_b]    = 1'b1;
  end

  // Bit 0 is forced clear so x0 can never look pending.
  always_ff @(posedge clk) begin
    if (reset) busy <= '0;
    else       busy <= ((busy & ~clr_vec) | set_vec) & ~NREG'(1);
  end

  // Look-ahead view so a consumer sees the same cycle's writeback/issue like the data bypass.
  assign busy1 = (rs1 != '0) && (set_vec[rs1] || (busy[rs1] && !clr_vec[rs1]));
  assign busy2 = (rs2 != '0) && (set_vec[rs2] || (busy[rs2] && !clr_vec[rs2]));
endmodule

// File: rtl/pipe_regfile.sv
// Two-write, two-read register file with write-through bypass, scoreboard and power-up clear.
module pipe_regfile
  import pipe_regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          reset,
  pipe_regfile_if.slave bus
);
  rf_state_e       state, nstate;
  logic [AW-1:0]   idx, nidx;
  logic [XLEN-1:0] rf [NREG];
  logic            run, wa, wb, set_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR;
      idx   <= '0;
    end else begin
      state <= nstate;
      idx   <= nidx;
    end
  end

  always_comb begin
    nstate = state;
    nidx   = idx;
    if (state == CLEAR) begin
      if (idx == AW'(NREG - 1)) nstate = RUN;
      else                      nidx   = idx + AW'(1);
    end
  end

  assign run    = (state == RUN) && !reset;
  assign wa     = run && bus.wea && (bus.rda != '0);
  assign wb     = run && bus.web && (bus.rdb != '0);
  assign set_en = run && bus.issue_valid && (bus.issue_rd != '0);

  // Port B is written last so it wins on an address collision.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == CLEAR) begin
        rf[idx] <= '0;
      end else begin
        if (wa) rf[bus.rda] <= bus.wda;
        if (wb) rf[bus.rdb] <= bus.wdb;
      end
    end
  end

  function automatic logic [XLEN-1:0] rd_port(input logic [AW-1:0] a);
    if (state != RUN || a == '0) return '0;
    if (wb && bus.rdb == a)      return bus.wdb;
    if (wa && bus.rda == a)      return bus.wda;
    return rf[a];
  endfunction

  assign bus.rv1       = rd_port(bus.rs1);
  assign bus.rv2       = rd_port(bus.rs2);
  assign bus.dbg_rdata = (state == RUN && bus.dbg_addr != '0) ? rf[bus.dbg_addr] : '0;
  assign bus.ready     = (state == RUN);

  regfile_scoreboard #(.NREG(NREG), .AW(AW)) u_sb (
    .clk      (clk),
    .reset    (reset),
    .set_en   (set_en),
    .set_addr (bus.issue_rd),
    .clr_a_en (wa),
    .clr_a    (bus.rda),
    .clr_b_en (wb),
    .clr_b    (bus.rdb),
    .rs1      (bus.rs1),
    .rs2      (bus.rs2),
    .busy1    (bus.busy1),
    .busy2    (bus.busy2)
  );
endmodule

// File: tb/tb_pipe_regfile.sv
// Directed bench for pipe_regfile: clear sequence, bypass, port priority, scoreboard, x0, reset restart.
module tb_pipe_regfile;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  pipe_regfile_if #(.XLEN(XLEN), .NREG(NREG)) bus ();
  pipe_regfile #(.XLEN(XLEN), .NREG(NREG)) dut (.clk(clk), .reset(reset), .bus(bus));

  task automatic idle();
    bus.wea = 0; bus.rda = '0; bus.wda = '0;
    bus.web = 0; bus.rdb = '0; bus.wdb = '0;
    bus.issue_valid = 0; bus.issue_rd = '0;
  endtask

  task automatic test_reset();
    idle();
    bus.rs1 = '0; bus.rs2 = '0; bus.dbg_addr = '0;
    reset = 1;
    @(posedge clk);
    @(negedge clk);
    reset = 0;
    for (int k = 0; k < NREG; k++) begin
      #1;
      tests++;
      if (bus.ready !== 1'b0) begin
        fails++; $display("FAIL ready_clear cyc%0d: got %b want 0", k, bus.ready);
      end
      @(negedge clk);
    end
    #1;
    tests++;
    if (bus.ready !== 1'b1) begin
      fails++; $display("FAIL ready_run: got %b want 1", bus.ready);
    end
    for (int a = 0; a < NREG; a++) begin
      bus.dbg_addr = AW'(a);
      #1;
      tests++;
      if (bus.dbg_rdata !== 32'h0) begin
        fails++; $display("FAIL dbg_zero r%0d: got %h want 0", a, bus.dbg_rdata);
      end
    end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    bus.wea = 1; bus.rda = 5; bus.wda = 32'hDEADBEEF; bus.rs1 = 5;
    #1;
    tests++;
    if (bus.rv1 !== 32'hDEADBEEF) begin
      fails++; $display("FAIL bypass_rv1: got %h want deadbeef", bus.rv1);
    end
    @(negedge clk);
    idle(); bus.dbg_addr = 5;
    #1;
    tests++;
    if (bus.dbg_rdata !== 32'hDEADBEEF) begin
      fails++; $display("FAIL dbg_r5: got %h want deadbeef", bus.dbg_rdata);
    end
    tests++;
    if (bus.rv1 !== 32'hDEADBEEF) begin
      fails++; $display("FAIL stored_rv1_r5: got %h want deadbeef", bus.rv1);
    end
  endtask

  task automatic test_port_priority();
    @(negedge clk);
    bus.wea = 1; bus.rda = 7; bus.wda = 32'h1;
    bus.web = 1; bus.rdb = 7; bus.wdb = 32'h2; bus.rs2 = 7;
    #1;
    tests++;
    if (bus.rv2 !== 32'h2) begin
      fails++; $display("FAIL prio_rv2: got %h want 2", bus.rv2);
    end
    @(negedge clk);
    idle(); bus.dbg_addr = 7;
    #1;
    tests++;
    if (bus.dbg_rdata !== 32'h2) begin
      fails++; $display("FAIL prio_r7: got %h want 2", bus.dbg_rdata);
    end
    // distinct addresses on both ports in one cycle
    bus.wea = 1; bus.rda = 10; bus.wda = 32'hAAAA0010;
    bus.web = 1; bus.rdb = 11; bus.wdb = 32'hBBBB0011;
    bus.rs1 = 10; bus.rs2 = 11;
    #1;
    tests++;
    if (bus.rv1 !== 32'hAAAA0010 || bus.rv2 !== 32'hBBBB0011) begin
      fails++; $display("FAIL dual_bypass: got %h/%h want aaaa0010/bbbb0011", bus.rv1, bus.rv2);
    end
    @(negedge clk);
    idle(); bus.dbg_addr = 10;
    #1;
    tests++;
    if (bus.dbg_rdata !== 32'hAAAA0010) begin
      fails++; $display("FAIL dual_r10: got %h want aaaa0010", bus.dbg_rdata);
    end
    bus.dbg_addr = 11;
    #1;
    tests++;
    if (bus.dbg_rdata !== 32'hBBBB0011) begin
      fails++; $display("FAIL dual_r11: got %h want bbbb0011", bus.dbg_rdata);
    end
  endtask

  task automatic test_scoreboard();
    @(negedge clk);
    bus.rs1 = 9; bus.rs2 = 9;
    #1;
    tests++;
    if (bus.busy1 !== 1'b0) begin
      fails++; $display("FAIL sb_idle: got %b want 0", bus.busy1);
    end
    bus.issue_valid = 1; bus.issue_rd = 9;
    @(negedge clk);
    idle();
    #1;
    tests++;
    if (bus.busy1 !== 1'b1 || bus.busy2 !== 1'b1) begin
      fails++; $display("FAIL sb_set: got %b/%b want 1/1", bus.busy1, bus.busy2);
    end
    bus.web = 1; bus.rdb = 9; bus.wdb = 32'h99; bus.issue_valid = 1; bus.issue_rd = 9;
    #1;
    tests++;
    if (bus.busy1 !== 1'b1) begin
      fails++; $display("FAIL sb_set_clr_comb: got %b want 1", bus.busy1);
    end
    @(negedge clk);
    idle();
    #1;
    tests++;
    if (bus.busy1 !== 1'b1) begin
      fails++; $display("FAIL sb_set_wins: got %b want 1", bus.busy1);
    end
    bus.wea = 1; bus.rda = 9; bus.wda = 32'h999;
    #1;
    tests++;
    if (bus.busy1 !== 1'b0 || bus.rv1 !== 32'h999) begin
      fails++; $display("FAIL sb_clr_bypass: got %b/%h want 0/999", bus.busy1, bus.rv1);
    end
    @(negedge clk);
    idle();
    #1;
    tests++;
    if (bus.busy1 !== 1'b0 || bus.busy2 !== 1'b0) begin
      fails++; $display("FAIL sb_cleared: got %b/%b want 0/0", bus.busy1, bus.busy2);
    end
  endtask

  task automatic test_x0();
    @(negedge clk);
    bus.wea = 1; bus.rda = 0; bus.wda = 32'h1234;
    bus.issue_valid = 1; bus.issue_rd = 0; bus.rs1 = 0;
    #1;
    tests++;
    if (bus.rv1 !== 32'h0 || bus.busy1 !== 1'b0) begin
      fails++; $display("FAIL x0_comb: got %h/%b want 0/0", bus.rv1, bus.busy1);
    end
    @(negedge clk);
    idle(); bus.dbg_addr = 0;
    #1;
    tests++;
    if (bus.rv1 !== 32'h0 || bus.busy1 !== 1'b0 || bus.dbg_rdata !== 32'h0) begin
      fails++; $display("FAIL x0_after: got %h/%b/%h want 0/0/0", bus.rv1, bus.busy1, bus.dbg_rdata);
    end
  endtask

  task automatic test_reset_restart();
    @(negedge clk);
    bus.wea = 1; bus.rda = 3; bus.wda = 32'hA5;
    bus.issue_valid = 1; bus.issue_rd = 12;
    @(negedge clk);
    idle(); bus.dbg_addr = 3; bus.rs1 = 12;
    #1;
    tests++;
    if (bus.dbg_rdata !== 32'hA5 || bus.busy1 !== 1'b1) begin
      fails++; $display("FAIL pre_reset: got %h/%b want a5/1", bus.dbg_rdata, bus.busy1);
    end
    // write in flight on the reset edge must be dropped
    reset = 1; bus.web = 1; bus.rdb = 4; bus.wdb = 32'h44;
    @(negedge clk);
    reset = 0; idle();
    for (int k = 0; k < 10; k++) @(negedge clk);
    bus.wea = 1; bus.rda = 3; bus.wda = 32'h77; bus.rs2 = 3;
    #1;
    tests++;
    if (bus.ready !== 1'b0 || bus.rv2 !== 32'h0) begin
      fails++; $display("FAIL clear_ignores: got %b/%h want 0/0", bus.ready, bus.rv2);
    end
    reset = 1;
    @(negedge clk);
    reset = 0; idle();
    for (int k = 0; k < NREG; k++) @(negedge clk);
    #1;
    tests++;
    if (bus.ready !== 1'b1) begin
      fails++; $display("FAIL restart_ready: got %b want 1", bus.ready);
    end
    bus.dbg_addr = 3;
    #1;
    tests++;
    if (bus.dbg_rdata !== 32'h0) begin
      fails++; $display("FAIL restart_r3: got %h want 0", bus.dbg_rdata);
    end
    bus.dbg_addr = 4;
    #1;
    tests++;
    if (bus.dbg_rdata !== 32'h0 || bus.busy1 !== 1'b0) begin
      fails++; $display("FAIL restart_r4_busy: got %h/%b want 0/0", bus.dbg_rdata, bus.busy1);
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_port_priority();
    test_scoreboard();
    test_x0();
    test_reset_restart();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
